// File: rtl/demux_router.sv
// Registered 1-to-N demultiplexer with a one-word holding register and valid/ready handshake per channel.
// Each word is steered by an explicit select or by a round-robin pointer. Words sent to an invalid select are dropped and counted.
module demux_router #(
    parameter int WIDTH    = 13,
    parameter int CHANNELS = 7,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [WIDTH-1:0]          in_value,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_value,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [SEL_W-1:0]          cur_chan,
    output logic                      drop_err,
    output logic [7:0]                drop_count
);

    localparam logic [SEL_W:0]   LP_CHANNELS = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LP_LAST     = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    r_value [CHANNELS];
    logic [CHANNELS-1:0] r_valid;
    logic [SEL_W-1:0]    r_ptr;
    logic                r_drop_err;
    logic [7:0]          r_drop_count;

    logic [SEL_W-1:0]    w_target;
    logic                w_in_range;
    logic [CHANNELS-1:0] w_free;
    logic                w_target_free;
    logic                w_accept;
    logic                w_drop;
    logic [CHANNELS-1:0] w_fill;

    assign w_target   = mode ? r_ptr : select;
    assign w_in_range = {1'b0, w_target} < LP_CHANNELS;
    // A full channel whose consumer takes its word this cycle can be refilled in the same cycle.
    assign w_free     = ~r_valid | out_ready;

    always_comb begin
        w_target_free = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_target == SEL_W'(k)) begin
                w_target_free = w_free[k];
            end
        end
    end

    assign in_ready = ~w_in_range | w_target_free;
    assign w_accept = in_valid & in_ready;
    assign w_drop   = w_accept & ~w_in_range;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_fill[gi] = w_accept & (w_target == SEL_W'(gi));
            assign out_value[gi*WIDTH +: WIDTH] = r_value[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_value[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_fill[k]) begin
                    r_valid[k] <= 1'b1;
                    r_value[k] <= in_value;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_drop_err   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_err <= w_drop;
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_accept && mode) begin
                r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign cur_chan   = w_target;
    assign drop_err   = r_drop_err;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: a scenario per task, checked against a transaction-level model of the channels.
module tb_demux_router;

    localparam int W = 13;
    localparam int C = 7;
    localparam int S = 3;

    logic           clk;
    logic           rst_n;
    logic           mode;
    logic [S-1:0]   select;
    logic [W-1:0]   in_value;
    logic           in_valid;
    logic           in_ready;
    logic [C*W-1:0] out_value;
    logic [C-1:0]   out_valid;
    logic [C-1:0]   out_ready;
    logic [S-1:0]   cur_chan;
    logic           drop_err;
    logic [7:0]     drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what each consumer slot holds, the round-robin position and the drop tally
    bit         mv   [C];
    logic [W-1:0] mval [C];
    int         mptr;
    int         mdrops;
    bit         merr;

    demux_router #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .select(select),
        .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
        .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
        .cur_chan(cur_chan), .drop_err(drop_err), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_target();
        return mode ? mptr : int'(select);
    endfunction

    function automatic bit m_ready();
        int t;
        t = m_target();
        return (t >= C) || !mv[t] || out_ready[t];
    endfunction

    function automatic logic [C-1:0] m_valid_vec();
        logic [C-1:0] r;
        for (int k = 0; k < C; k++) r[k] = mv[k];
        return r;
    endfunction

    function automatic logic [C*W-1:0] m_value_vec();
        logic [C*W-1:0] r;
        for (int k = 0; k < C; k++) r[k*W +: W] = mval[k];
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < C; k++) begin
            mv[k]   = 1'b0;
            mval[k] = '0;
        end
        mptr = 0; mdrops = 0; merr = 1'b0;
    endtask

    // Advance the model by one transfer cycle from the current inputs, then clock the DUT
    task automatic tick();
        int t;
        bit acc;
        t   = m_target();
        acc = in_valid && m_ready();
        for (int k = 0; k < C; k++) if (mv[k] && out_ready[k]) mv[k] = 1'b0;
        merr = 1'b0;
        if (acc) begin
            if (t < C) begin
                mv[t]   = 1'b1;
                mval[t] = in_value;
            end else begin
                merr = 1'b1;
                if (mdrops < 255) mdrops++;
            end
            if (mode) mptr = (mptr + 1) % C;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; select = '0; in_value = '0; in_valid = 1'b0; out_ready = '0;
        m_reset();
        #3;
        n_tests++;
        if (out_valid !== '0 || out_value !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b value=%h, want 0/0", out_valid, out_value);
        end
        n_tests++;
        if (drop_count !== 8'd0 || drop_err !== 1'b0 || cur_chan !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d err=%b chan=%0d, want 0/0/0", drop_count, drop_err, cur_chan);
        end
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] reset released");
    endtask

    task automatic test_addressed_fill();
        logic [W-1:0] words [C];
        words = '{13'h0E23, 13'h0A11, 13'h1234, 13'h0777, 13'h1ABC, 13'h0F0F, 13'h1FE3};
        mode = 1'b0; out_ready = '0; in_valid = 1'b1;
        for (int k = 0; k < C; k++) begin
            select = S'(k); in_value = words[k];
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready ch%0d: in_ready=%b want 1", k, in_ready);
            end
            tick();
            n_tests++;
            if (out_valid !== m_valid_vec() || out_value !== m_value_vec()) begin
                n_fail++;
                $display("FAIL fill_state ch%0d: valid=%b value=%h want %b %h", k, out_valid, out_value, m_valid_vec(), m_value_vec());
            end
            $display("[TB] fill ch%0d word %h", k, words[k]);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        mode = 1'b0; select = 3'd3; in_value = 13'h1555; in_valid = 1'b1; out_ready = '0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_blocked: in_ready=%b want 0", in_ready);
        end
        tick();
        n_tests++;
        if (out_value[3*W +: W] !== 13'h0777 || out_valid !== m_valid_vec()) begin
            n_fail++;
            $display("FAIL bp_hold: ch3=%h valid=%b want 0777 %b", out_value[3*W +: W], out_valid, m_valid_vec());
        end
        out_ready = 7'b0001000;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_refill_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid[3] !== 1'b1 || out_value[3*W +: W] !== 13'h1555 || out_valid !== m_valid_vec()) begin
            n_fail++;
            $display("FAIL bp_refill: valid=%b ch3=%h want %b 1555", out_valid, out_value[3*W +: W], m_valid_vec());
        end
        in_valid = 1'b0; out_ready = '0;
        $display("[TB] backpressure drain-and-refill ch3");
    endtask

    task automatic test_invalid_select();
        mode = 1'b0; select = 3'd7; in_valid = 1'b1; out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_value = W'($urandom);
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_ready %0d: in_ready=%b want 1", i, in_ready);
            end
            tick();
            n_tests++;
            if (drop_err !== 1'b1 || out_valid !== m_valid_vec()) begin
                n_fail++;
                $display("FAIL drop_pulse %0d: err=%b valid=%b want 1 %b", i, drop_err, out_valid, m_valid_vec());
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (drop_err !== 1'b0 || drop_count !== 8'd3) begin
            n_fail++;
            $display("FAIL drop_count3: err=%b count=%0d want 0 3", drop_err, drop_count);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (drop_count !== 8'd255 || mdrops != 255) begin
            n_fail++;
            $display("FAIL drop_saturate: count=%0d want 255", drop_count);
        end
        $display("[TB] drops counted, saturated at %0d", drop_count);
    endtask

    task automatic test_rr_wrap();
        int exp_t [9];
        exp_t = '{0, 1, 2, 3, 4, 5, 6, 0, 1};
        mode = 1'b1; out_ready = '1; in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_value = W'($urandom);
            #1;
            n_tests++;
            if (cur_chan !== S'(exp_t[i]) || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_target %0d: chan=%0d ready=%b want %0d 1", i, cur_chan, in_ready, exp_t[i]);
            end
            tick();
            n_tests++;
            if (out_valid !== m_valid_vec() || out_value !== m_value_vec()) begin
                n_fail++;
                $display("FAIL rr_state %0d: valid=%b value=%h want %b %h", i, out_valid, out_value, m_valid_vec(), m_value_vec());
            end
            $display("[TB] rr word %0d -> ch%0d", i, exp_t[i]);
        end
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (cur_chan !== 3'd2) begin
            n_fail++;
            $display("FAIL rr_end_ptr: chan=%0d want 2", cur_chan);
        end
    endtask

    task automatic test_rr_stall_switch();
        mode = 1'b0; select = 3'd4; in_value = 13'h0444; in_valid = 1'b1; out_ready = 7'b1101111;
        tick();
        mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_value = W'($urandom);
            tick();
        end
        in_value = 13'h1004;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || cur_chan !== 3'd4) begin
            n_fail++;
            $display("FAIL rr_stall: ready=%b chan=%0d want 0 4", in_ready, cur_chan);
        end
        tick();
        n_tests++;
        if (cur_chan !== 3'd4 || out_value[4*W +: W] !== 13'h0444) begin
            n_fail++;
            $display("FAIL rr_stall_hold: chan=%0d ch4=%h want 4 0444", cur_chan, out_value[4*W +: W]);
        end
        mode = 1'b0; select = 3'd2; in_value = 13'h0222;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_ready: ready=%b want 1", in_ready);
        end
        tick();
        mode = 1'b1; in_valid = 1'b0;
        #1;
        n_tests++;
        if (cur_chan !== 3'd4 || out_value !== m_value_vec() || out_valid !== m_valid_vec()) begin
            n_fail++;
            $display("FAIL switch_state: chan=%0d valid=%b value=%h want 4 %b %h", cur_chan, out_valid, out_value, m_valid_vec(), m_value_vec());
        end
        $display("[TB] rr stall at ch4, addressed word to ch2");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom);
            select    = S'($urandom_range(0, 7));
            in_value  = W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = C'($urandom);
            #1;
            n_tests++;
            if (in_ready !== m_ready() || cur_chan !== S'(m_target())) begin
                n_fail++;
                $display("FAIL rand_comb %0d: ready=%b chan=%0d want %b %0d", i, in_ready, cur_chan, m_ready(), m_target());
            end
            tick();
            n_tests++;
            if (out_valid !== m_valid_vec() || out_value !== m_value_vec() ||
                drop_err !== merr || drop_count !== 8'(mdrops)) begin
                n_fail++;
                $display("FAIL rand_state %0d: valid=%b value=%h err=%b cnt=%0d want %b %h %b %0d",
                         i, out_valid, out_value, drop_err, drop_count, m_valid_vec(), m_value_vec(), merr, mdrops);
            end
        end
        in_valid = 1'b0;
        $display("[TB] random mix done, drops=%0d", mdrops);
    endtask

    task automatic test_async_reset();
        mode = 1'b0; out_ready = '0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            select = S'(k); in_value = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        n_tests++;
        if (out_valid !== '0 || drop_count !== 8'd0 || out_value !== '0) begin
            n_fail++;
            $display("FAIL areset_now: valid=%b count=%0d value=%h want 0", out_valid, drop_count, out_value);
        end
        mode = 1'b1;
        #1;
        n_tests++;
        if (cur_chan !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_ptr: chan=%0d want 0", cur_chan);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_value = 13'h0ABC; out_ready = '0;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 7'b0000001 || out_value[W-1:0] !== 13'h0ABC || out_valid !== m_valid_vec()) begin
            n_fail++;
            $display("FAIL areset_first: valid=%b ch0=%h want 0000001 0abc", out_valid, out_value[W-1:0]);
        end
        $display("[TB] async reset mid-run, first rr word to ch0");
    endtask

    initial begin
        test_reset();
        test_addressed_fill();
        test_backpressure();
        test_invalid_select();
        test_rr_wrap();
        test_rr_stall_switch();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_router.md
# demux_router

Registered, flow-controlled 1-to-N demultiplexer for WIDTH-bit words. It is the parametrised successor of the combinational 13-bit 1-to-7 demux. Each output channel has a one-entry holding register with a valid/ready handshake. Words are steered either by an explicit select or by an internal round-robin pointer. Invalid selects are dropped and counted. The block sits between a single producer and up to 8 independent consumers.

## Interface
Parameters:
- WIDTH, 13, data word width (≥1)
- CHANNELS, 7, number of output channels (2..8)
- SEL_W, 3, select/pointer width; must satisfy 2**SEL_W ≥ CHANNELS

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- mode  in  1  0 = addressed (use select), 1 = round-robin (use internal pointer)
- select  in  SEL_W  target channel in addressed mode
- in_value  in  WIDTH  input word
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- out_value  out  CHANNELS*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  channel k holds a word
- out_ready  in  CHANNELS  consumer k takes its word this cycle
- cur_chan  out  SEL_W  current target index (select or pointer)
- drop_err  out  1  one-cycle pulse: word dropped for invalid select
- drop_count  out  8  saturating count of dropped words

## Operation
- Target: t = mode ? rr_ptr : select. cur_chan = t (combinational).
- Channel k is free when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 in the same cycle (drain-and-refill).
- in_ready = (t ≥ CHANNELS) or channel t is free. The computation is combinational and must not depend on in_valid.
- Accept = in_valid & in_ready.
- Accept with t < CHANNELS:
  - out_value[t] ← in_value
  - out_valid[t] ← 1
- Accept with t ≥ CHANNELS (addressed mode only):
  - the word is discarded
  - drop_err ← 1 for one cycle
  - drop_count increments and saturates at 255
  - no channel changes
- Channel k drains when out_valid[k] & out_ready[k] and the channel is not refilled in the same cycle: out_valid[k] ← 0. out_value[k] holds its last word.
- out_ready to an empty channel is ignored.
- Round-robin pointer rr_ptr advances only on an accept while mode=1. It goes 0,1,…,CHANNELS-1,0. rr_ptr never holds a value ≥ CHANNELS.
- A blocked round-robin target stalls the input (in_ready=0). The pointer does not skip busy channels.
- Switching mode takes effect the same cycle. rr_ptr keeps its value across switches and is not updated in mode 0.
- Channels are fully independent: any mix of drains and one fill per cycle.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_value=0, rr_ptr=0, drop_err=0, drop_count=0. The block holds this state until the first rising edge after rst_n returns to 1.
- Reset asserted mid-transfer discards all held words. No partial state survives.
- Latency: a word accepted at edge n appears with out_valid[t]=1 after edge n.
- Throughput: 1 word/cycle, including back-to-back words to the same channel when its consumer keeps out_ready=1.
- drop_err is high for exactly the cycle after the dropping edge.
- in_valid with in_ready=0: no state change. The producer must hold in_value/select stable until accepted.

## Test plan
- Reset then addressed fill: mode=0, send 13'h0E23 to select=0 … 13'h1FE3 to select=6 with out_ready=0 → each out_valid[k]=1 one cycle after its accept, correct word in each slot, in_ready stays 1 throughout.
- Backpressure: channel 3 full, out_ready[3]=0, send to select=3 → in_ready=0, out_value[3] unchanged. Raise out_ready[3] → new word accepted the same cycle and out_valid[3] stays 1 (drain-and-refill).
- Invalid select: mode=0, select=7, CHANNELS=7, in_valid for 3 cycles → in_ready=1, three drop_err pulses, drop_count=3, all out_valid unchanged. Drive 300 drops → drop_count=255.
- Round-robin wrap: mode=1, out_ready all 1, 9 consecutive words → targets 0,1,2,3,4,5,6,0,1, cur_chan tracks them, rr_ptr=2 at end.
- Round-robin stall and mode switch: mode=1, rr_ptr=4, channel 4 full with out_ready[4]=0 → in_ready=0, rr_ptr stays 4. Switch to mode=0, select=2 → accepted, rr_ptr still 4.
- Async reset mid-run: assert rst_n=0 between edges with several channels valid → out_valid=0 immediately, drop_count=0, rr_ptr=0. First accept after release goes to channel 0 in mode 1.
